ps2_packet_assembler: RTL and testbench
=======================================

Name: ps2_packet_assembler

Overview:
- Parametrised PS/2-style packet framer with datapath. Consumes a qualified byte stream and aligns packets on a sync bit in the first byte.
- Collects PKT_BYTES bytes, then presents the whole packet on a held output register with a one-cycle done strobe.
- Sits between the PS/2 byte receiver and mouse/keyboard decode logic.
- Next generation of the fixed 3-byte parser: adds variable packet length, a configurable sync bit, an input valid qualifier, a stable output register, a sync-discard strobe, and an optional inter-byte timeout.

Parameters:
- BYTE_W, 8, width of one stream byte.
- PKT_BYTES, 3, bytes per packet; legal range 2..16.
- SYNC_BIT, 3, bit index in the first byte that must be 1 to start a packet; must be < BYTE_W.
- TIMEOUT_CYC, 1024, maximum idle cycles allowed between bytes of one packet. Used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  in carries a new byte this cycle
- in  in  BYTE_W  stream byte
- out_bytes  out  PKT_BYTES*BYTE_W  last completed packet; first byte in the MSBs
- done  out  1  one-cycle strobe: out_bytes was updated this cycle
- sync_drop  out  1  one-cycle strobe: a byte was discarded while hunting for sync
- timeout  out  1  one-cycle strobe: a partial packet was abandoned (tied 0 without the feature)

Behaviour:
- Reset (clk edge with reset=1):
  - state=SEARCH, byte index=0, shift register=0.
  - out_bytes=0, done=0, sync_drop=0, timeout=0.
  - Reset mid-packet discards partial data and produces no strobe.
- A byte is accepted only on an edge where in_valid=1. When in_valid=0, in is don't-care and no state changes, except the timeout counter.
- SEARCH state:
  - Accepted byte with in[SYNC_BIT]=1: store it as byte 0, set index=1, go to COLLECT.
  - Accepted byte with in[SYNC_BIT]=0: drop it. sync_drop=1 in the following cycle. Stay in SEARCH.
- COLLECT state:
  - Each accepted byte shifts into the shift register and increments the index. The sync bit is not checked.
  - On accepting byte PKT_BYTES-1: load out_bytes with the complete packet, go to SEARCH, index=0.
  - done=1 in the following cycle.
- Latency: done and the new out_bytes appear one cycle after the edge that accepted the last byte.
- out_bytes holds its value until the next completion. It never shows partial packets.
- Back-to-back: in the cycle where done=1 the FSM is already in SEARCH. A valid sync byte in that cycle starts the next packet. Sustained in_valid=1 therefore yields one done every PKT_BYTES cycles.
- Strobes (done, sync_drop, timeout) are registered and last exactly one cycle. They are mutually exclusive by construction.
- Width rule: the index counter is $clog2(PKT_BYTES) bits wide. Its terminal compare is against PKT_BYTES-1, so a non-power-of-two PKT_BYTES needs no wrap logic.

Optional Feature:
- Macro: PS2_PACKET_TIMEOUT_EN.
- Defined:
  - A gap counter of $clog2(TIMEOUT_CYC+1) bits clears on every accepted byte. It increments each cycle in COLLECT with in_valid=0 and is held at 0 in SEARCH.
  - When the counter reaches TIMEOUT_CYC: discard the partial packet, go to SEARCH, index=0, timeout=1 in the next cycle. out_bytes is unchanged.
  - If in_valid=1 on the same edge the limit is reached, the byte wins: it is accepted and the counter clears.
- Undefined: no counter is instantiated, timeout is tied to 0, and a partial packet waits indefinitely.

Decomposition:
- Package ps2_pkg holds:
  - the state enum typedef {SEARCH, COLLECT};
  - default localparams for BYTE_W, PKT_BYTES and SYNC_BIT;
  - a width function for the index counter.
- One sub-module, ps2_gap_timer: the gap counter with clear/enable/expire ports. It is instantiated only under PS2_PACKET_TIMEOUT_EN.
- FSM and datapath stay in the top module.

Test Plan:
- Reset, then the continuous stream 0x2C,0x81,0x09 with in_valid=1 -> done=1 exactly 1 cycle after 0x09, out_bytes=0x2C8109. sync_drop stays 0.
- Stream 0x00,0x01,0x08,0xAA,0xBB -> sync_drop pulses twice (for 0x00 and 0x01). Then done with out_bytes=0x08AABB.
- in_valid toggled 1,0,0,1,0,1 carrying 0x18,xx,xx,0x22,xx,0x33 -> one done with out_bytes=0x182233. Bytes on invalid cycles are ignored.
- Two sync packets back-to-back (six consecutive valid bytes) -> done on cycles 3 and 6 after the first byte. out_bytes is held between the two strobes.
- Reset asserted after byte 2 of a packet, then a fresh packet 0x0F,0x01,0x02 -> no done for the partial packet, then out_bytes=0x0F0102. All outputs are 0 in the cycle after reset.
- With PS2_PACKET_TIMEOUT_EN and TIMEOUT_CYC=4: byte 0x08, then 4 idle cycles -> timeout=1 and out_bytes unchanged. Repeat with the next byte arriving exactly on the 4th idle cycle -> no timeout.

Source files
------------

// File: rtl/ps2_pkg.sv
// ============================================================================
// ps2_pkg : shared types, defaults and width helper for the PS/2 packet framer
// Revision: 1.0
// ============================================================================
`default_nettype none

package ps2_pkg;

    typedef enum logic [0:0] {
        SEARCH  = 1'b0,
        COLLECT = 1'b1
    } ps2_state_e;

    localparam int BYTE_W_DEF    = 8;
    localparam int PKT_BYTES_DEF = 3;
    localparam int SYNC_BIT_DEF  = 3;

    // Index counter width; never below one bit so PKT_BYTES=2 still has a counter.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_gap_timer.sv
// ============================================================================
// ps2_gap_timer : inter-byte idle counter; expire fires on the edge it reaches the limit
// Revision: 1.0
// ============================================================================
`default_nettype none

module ps2_gap_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Lookahead: the idle edge that takes the count to TIMEOUT_CYC is the abandon edge.
    assign expire = enable && !clear && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

`default_nettype wire

// File: rtl/ps2_packet_assembler.sv
// ============================================================================
// ps2_packet_assembler : sync-aligned PKT_BYTES packet framer with held output.
// Optional inter-byte timeout enabled by defining PS2_PACKET_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ps2_packet_assembler
    import ps2_pkg::*;
#(
    parameter int BYTE_W      = BYTE_W_DEF,
    parameter int PKT_BYTES   = PKT_BYTES_DEF,
    parameter int SYNC_BIT    = SYNC_BIT_DEF,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [BYTE_W-1:0]           in,
    output logic [PKT_BYTES*BYTE_W-1:0] out_bytes,
    output logic                        done,
    output logic                        sync_drop,
    output logic                        timeout
);

    localparam int IDX_W = idx_width(PKT_BYTES);
    localparam int SH_W  = (PKT_BYTES - 1) * BYTE_W;

    ps2_state_e                  state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [SH_W-1:0]             shift_q, shift_d;
    logic [PKT_BYTES*BYTE_W-1:0] out_q, out_d;
    logic                        done_q, done_d;
    logic                        drop_q, drop_d;
    logic                        to_q, to_d;
    logic                        gap_expire;

`ifdef PS2_PACKET_TIMEOUT_EN
    ps2_gap_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_gap_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  ((state_q == SEARCH) || in_valid),
        .enable ((state_q == COLLECT) && !in_valid),
        .expire (gap_expire)
    );
`else
    assign gap_expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        out_d   = out_q;
        done_d  = 1'b0;
        drop_d  = 1'b0;
        to_d    = 1'b0;
        if (in_valid) begin
            case (state_q)
                SEARCH: begin
                    if (in[SYNC_BIT]) begin
                        shift_d = SH_W'({shift_q, in});
                        idx_d   = IDX_W'(1);
                        state_d = COLLECT;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
                COLLECT: begin
                    if (idx_q == IDX_W'(PKT_BYTES - 1)) begin
                        // Shift register holds bytes 0..N-2; the live byte completes it.
                        out_d   = {shift_q, in};
                        done_d  = 1'b1;
                        idx_d   = '0;
                        state_d = SEARCH;
                    end else begin
                        shift_d = SH_W'({shift_q, in});
                        idx_d   = idx_q + 1'b1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end else if (gap_expire) begin
            idx_d   = '0;
            state_d = SEARCH;
            to_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEARCH;
            idx_q   <= '0;
            shift_q <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
            to_q    <= to_d;
        end
    end

    assign out_bytes = out_q;
    assign done      = done_q;
    assign sync_drop = drop_q;
    assign timeout   = to_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_packet_assembler.sv
// ============================================================================
// tb_ps2_packet_assembler : scoreboard bench with queue-based packet reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ps2_packet_assembler;

    localparam int BW  = 8;
    localparam int PB  = 3;
    localparam int SB  = 3;
    localparam int TO  = 4;
    localparam int PW  = PB * BW;

    localparam int K_DONE = 1;
    localparam int K_DROP = 2;
    localparam int K_TO   = 3;

    typedef struct {
        int            kind;
        logic [PW-1:0] data;
        int            cyc;
    } ev_t;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [BW-1:0] in_byte;
    logic [PW-1:0] out_bytes;
    logic          done;
    logic          sync_drop;
    logic          timeout;

    ps2_packet_assembler #(
        .BYTE_W      (BW),
        .PKT_BYTES   (PB),
        .SYNC_BIT    (SB),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in        (in_byte),
        .out_bytes (out_bytes),
        .done      (done),
        .sync_drop (sync_drop),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic rst_edge = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= reset;
    end

    // Reference model: pending bytes of the packet in progress and idle run length.
    ev_t           sb[$];
    logic [BW-1:0] part[$];
    int            gap = 0;

    function automatic void model_byte(input bit v, input logic [BW-1:0] b, input int now);
        logic [PW-1:0] d;
        if (v) begin
            gap = 0;
            if (part.size() == 0) begin
                if (b[SB]) part.push_back(b);
                else sb.push_back('{K_DROP, '0, now + 1});
            end else begin
                part.push_back(b);
                if (part.size() == PB) begin
                    d = '0;
                    foreach (part[i]) d = (d << BW) | PW'(part[i]);
                    sb.push_back('{K_DONE, d, now + 1});
                    part.delete();
                end
            end
        end else if (part.size() > 0) begin
`ifdef PS2_PACKET_TIMEOUT_EN
            gap++;
            if (gap == TO) begin
                sb.push_back('{K_TO, '0, now + 1});
                part.delete();
                gap = 0;
            end
`endif
        end
    endfunction

    task automatic step(input bit v, input logic [BW-1:0] b);
        in_valid = v;
        in_byte  = v ? b : BW'($urandom);
        model_byte(v, b, cyc);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset    = 1'b1;
        in_valid = 1'(($urandom));
        in_byte  = BW'($urandom);
        part.delete();
        gap = 0;
        repeat (cycles) @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever a strobe appears, and tracks the held packet.
    logic [PW-1:0] held = '0;
    int            kind_act;
    ev_t           e;

    always @(negedge clk) begin
        if (rst_edge) begin
            held = '0;
            n_cmp++;
            if (out_bytes !== '0 || done !== 1'b0 || sync_drop !== 1'b0 || timeout !== 1'b0) begin
                n_err++;
                $display("FAIL reset_outputs cyc=%0d got out=%h done=%b drop=%b to=%b, want all 0",
                         cyc, out_bytes, done, sync_drop, timeout);
            end
        end else if (done === 1'b1 || sync_drop === 1'b1 || timeout === 1'b1) begin
            kind_act = (32'(done) + 32'(sync_drop) + 32'(timeout) > 1) ? -1 :
                       done ? K_DONE : sync_drop ? K_DROP : K_TO;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_strobe cyc=%0d got kind=%0d out=%h, want no strobe",
                         cyc, kind_act, out_bytes);
            end else begin
                e = sb.pop_front();
                if (kind_act != e.kind || cyc != e.cyc ||
                    (e.kind == K_DONE && out_bytes !== e.data)) begin
                    n_err++;
                    $display("FAIL strobe cyc=%0d got kind=%0d out=%h, want kind=%0d out=%h at cyc=%0d",
                             cyc, kind_act, out_bytes, e.kind, e.data, e.cyc);
                end
                if (e.kind == K_DONE) held = e.data;
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missed_strobe cyc=%0d got none, want kind=%0d out=%h at cyc=%0d",
                     cyc, e.kind, e.data, e.cyc);
            if (e.kind == K_DONE) held = e.data;
        end
        n_cmp++;
        if (out_bytes !== held) begin
            n_err++;
            $display("FAIL out_hold cyc=%0d got out=%h, want %h", cyc, out_bytes, held);
        end
    end

    logic [BW-1:0] rb;
    int            r;

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_byte  = '0;
        do_reset(2);

        // Single packet, continuous valid
        step(1, 8'h2C); step(1, 8'h81); step(1, 8'h09);
        step(0, 8'h00); step(0, 8'h00);
        // Sync hunting
        step(1, 8'h00); step(1, 8'h01); step(1, 8'h08); step(1, 8'hAA); step(1, 8'hBB);
        step(0, 8'h00);
        // Gapped valid qualifier
        step(1, 8'h18); step(0, 8'hFF); step(0, 8'hFF); step(1, 8'h22); step(0, 8'hFF); step(1, 8'h33);
        step(0, 8'h00);
        // Back-to-back packets
        step(1, 8'h48); step(1, 8'h11); step(1, 8'h22);
        step(1, 8'hF8); step(1, 8'h33); step(1, 8'h44);
        step(0, 8'h00); step(0, 8'h00);
        // Reset mid-packet, then fresh packet
        step(1, 8'h08); step(1, 8'h11);
        do_reset(1);
        step(1, 8'h0F); step(1, 8'h01); step(1, 8'h02);
        step(0, 8'h00); step(0, 8'h00);
`ifdef PS2_PACKET_TIMEOUT_EN
        // Timeout after TO idle cycles, then a byte on the last idle slot
        step(1, 8'h08); repeat (TO) step(0, 8'h00);
        step(0, 8'h00); step(0, 8'h00);
        step(1, 8'h08); repeat (TO - 1) step(0, 8'h00);
        step(1, 8'h55); step(1, 8'h66);
        step(0, 8'h00); step(0, 8'h00);
`endif

        for (int i = 0; i < 800; i++) begin
            r  = int'($urandom_range(0, 99));
            rb = BW'($urandom);
            if (r < 2) do_reset(1);
            else step(r < 70, rb);
        end
        repeat (TO + 4) step(0, 8'h00);

        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got %0d pending events, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
